// File: rtl/mem_pkg.sv
// Shared opcodes, bus direction codes and FSM state type for the memory access unit.
package mem_pkg;

  localparam logic [3:0] OP_LDR = 4'b1101;
  localparam logic [3:0] OP_STR = 4'b1110;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

  // Smallest counter width able to hold the value 'limit'.
  function automatic int unsigned cnt_width(input int unsigned limit);
    int unsigned w;
    w = 1;
    while ((w < 32) && ((32'd1 << w) <= limit)) w++;
    return w;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response and RAM bus signals of the memory access unit.
// slave = the unit itself; master = execute stage plus RAM side.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) ();

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        opcode;
  logic [31:0]       address;
  logic [DATA_W-1:0] data;
  logic [DATA_W-1:0] mem_din;
  logic              mem_ready;
  logic              bus_en;
  logic [ADDR_W-1:0] addr_bus;
  logic              rw;
  logic [DATA_W-1:0] mem_dout;
  logic              ldr_valid;
  logic              ldr_sel;
  logic [DATA_W-1:0] ldr_data;
  logic              store_done;
  logic              busy;
  logic              err;

  modport slave (
    input  req_valid, opcode, address, data, mem_din, mem_ready,
    output req_ready, bus_en, addr_bus, rw, mem_dout,
           ldr_valid, ldr_sel, ldr_data, store_done, busy, err
  );

  modport master (
    output req_valid, opcode, address, data, mem_din, mem_ready,
    input  req_ready, bus_en, addr_bus, rw, mem_dout,
           ldr_valid, ldr_sel, ldr_data, store_done, busy, err
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Saturating up-counter with synchronous clear/enable; eq_o flags count == LIMIT.
module mem_wait_counter
  import mem_pkg::*;
#(
  parameter int unsigned LIMIT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic eq_o
);

  localparam int unsigned CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != LIM))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign eq_o = (cnt_q == LIM);

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle LDR/STR engine between execute stage and data RAM.
// Define MEM_TIMEOUT_EN to abort an ACCESS after TIMEOUT_CYCLES cycles with an err pulse.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int          DATA_W         = 32,
  parameter int          ADDR_W         = 16,
  parameter int unsigned WAIT_STATES    = 0,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave io
);

  state_e            state_q, state_d;
  logic              bus_en_q, bus_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ldr_valid_q, ldr_valid_d;
  logic [DATA_W-1:0] ldr_data_q, ldr_data_d;
  logic              store_done_q, store_done_d;
  logic              err_q, err_d;

  logic accept, in_access, wait_done, complete, timeout;

  assign in_access = (state_q == ACCESS);
  assign accept    = (state_q == IDLE) && io.req_valid && is_mem_op(io.opcode);
  assign complete  = in_access && wait_done && io.mem_ready;

  mem_wait_counter #(.LIMIT(WAIT_STATES)) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (in_access),
    .eq_o  (wait_done)
  );

`ifdef MEM_TIMEOUT_EN
  // Counter reads k in the k-th ACCESS cycle, so matching TIMEOUT_CYCLES-1 aborts
  // after exactly TIMEOUT_CYCLES cycles in ACCESS.
  localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  logic to_hit;

  mem_wait_counter #(.LIMIT(TO_LIMIT)) u_timeout_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept),
    .en_i  (in_access),
    .eq_o  (to_hit)
  );

  assign timeout = in_access && !complete && to_hit;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    bus_en_d     = bus_en_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    dout_d       = dout_q;
    ldr_data_d   = ldr_data_q;
    ldr_valid_d  = 1'b0;
    store_done_d = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = ACCESS;
          bus_en_d = 1'b1;
          addr_d   = io.address[ADDR_W-1:0];
          rw_d     = (io.opcode == OP_STR) ? RW_WRITE : RW_READ;
          dout_d   = (io.opcode == OP_STR) ? io.data : '0;
        end
      end
      ACCESS: begin
        if (complete || timeout) begin
          bus_en_d = 1'b0;
          addr_d   = '0;
          rw_d     = RW_READ;
          dout_d   = '0;
          state_d  = IDLE;
        end
        if (complete) begin
          if (rw_q == RW_WRITE) begin
            store_done_d = 1'b1;
          end else begin
            ldr_data_d  = io.mem_din;
            ldr_valid_d = 1'b1;
            state_d     = RESP;
          end
        end else if (timeout) begin
          err_d = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_en_q     <= 1'b0;
      addr_q       <= '0;
      rw_q         <= RW_READ;
      dout_q       <= '0;
      ldr_valid_q  <= 1'b0;
      ldr_data_q   <= '0;
      store_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bus_en_q     <= bus_en_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      dout_q       <= dout_d;
      ldr_valid_q  <= ldr_valid_d;
      ldr_data_q   <= ldr_data_d;
      store_done_q <= store_done_d;
      err_q        <= err_d;
    end
  end

  assign io.req_ready  = (state_q == IDLE);
  assign io.busy       = (state_q != IDLE);
  assign io.bus_en     = bus_en_q;
  assign io.addr_bus   = addr_q;
  assign io.rw         = rw_q;
  assign io.mem_dout   = dout_q;
  assign io.ldr_valid  = ldr_valid_q;
  assign io.ldr_sel    = ldr_valid_q;
  assign io.ldr_data   = ldr_data_q;
  assign io.store_done = store_done_q;
  assign io.err        = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: dut0 uses WAIT_STATES=0, dut3 uses WAIT_STATES=3.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    bit          is_load;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst0, rst3;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

`ifdef MEM_TIMEOUT_EN
  localparam int LOW_CYC = 6;
`else
  localparam int LOW_CYC = 10;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_access_unit_if #(.DATA_W(32), .ADDR_W(16)) bus0 ();
  mem_access_unit_if #(.DATA_W(32), .ADDR_W(16)) bus3 ();

  mem_access_unit #(.DATA_W(32), .ADDR_W(16), .WAIT_STATES(0), .TIMEOUT_CYCLES(8)) dut0 (
    .clk (clk), .rst (rst0), .io (bus0.slave));

  mem_access_unit #(.DATA_W(32), .ADDR_W(16), .WAIT_STATES(3), .TIMEOUT_CYCLES(8)) dut3 (
    .clk (clk), .rst (rst3), .io (bus3.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.req_valid = 1'b0; bus0.opcode = 4'h0; bus0.address = '0; bus0.data = '0;
    bus0.mem_din = '0; bus0.mem_ready = 1'b0;
    bus3.req_valid = 1'b0; bus3.opcode = 4'h0; bus3.address = '0; bus3.data = '0;
    bus3.mem_din = '0; bus3.mem_ready = 1'b0;
  endtask

  // Advances until dut0 pulses ldr_valid or store_done, at most max cycles.
  task automatic wait_resp0(input int max, output bit got, output bit is_ld,
                            output logic [31:0] d, output int at);
    got = 1'b0; is_ld = 1'b0; d = '0; at = -1;
    for (int i = 0; i <= max; i++) begin
      if (bus0.ldr_valid === 1'b1 || bus0.store_done === 1'b1) begin
        got = 1'b1; is_ld = bus0.ldr_valid; d = bus0.ldr_data; at = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    logic [7:0] f0, f3;
    rst0 = 1'b1; rst3 = 1'b1;
    clear_inputs();
    tick(); tick();
    rst0 = 1'b0; rst3 = 1'b0;
    f0 = {bus0.req_ready, bus0.busy, bus0.bus_en, bus0.rw, bus0.ldr_valid, bus0.ldr_sel, bus0.store_done, bus0.err};
    f3 = {bus3.req_ready, bus3.busy, bus3.bus_en, bus3.rw, bus3.ldr_valid, bus3.ldr_sel, bus3.store_done, bus3.err};
    total++; if (f0 !== 8'b1000_0000) begin bad++; $display("FAIL reset_flags0: got %b required 10000000", f0); end
    total++; if (f3 !== 8'b1000_0000) begin bad++; $display("FAIL reset_flags3: got %b required 10000000", f3); end
    total++; if (bus0.addr_bus !== 16'h0 || bus0.mem_dout !== 32'h0 || bus0.ldr_data !== 32'h0) begin
      bad++; $display("FAIL reset_data0: addr=%h dout=%h ldr=%h required all 0", bus0.addr_bus, bus0.mem_dout, bus0.ldr_data); end
    total++; if (bus3.addr_bus !== 16'h0 || bus3.mem_dout !== 32'h0 || bus3.ldr_data !== 32'h0) begin
      bad++; $display("FAIL reset_data3: addr=%h dout=%h ldr=%h required all 0", bus3.addr_bus, bus3.mem_dout, bus3.ldr_data); end
  endtask

  task automatic test_load_w0();
    int acc, at; bit got, is_ld; logic [31:0] d; exp_t e;
    bus0.mem_ready = 1'b1; bus0.mem_din = 32'hDEAD_BEEF;
    bus0.req_valid = 1'b1; bus0.opcode = OP_LDR; bus0.address = 32'h0001_0040; bus0.data = 32'hFFFF_FFFF;
    total++; if (bus0.req_ready !== 1'b1) begin bad++; $display("FAIL ld_ready: got %b required 1", bus0.req_ready); end
    acc = cyc + 1;
    exp_q.push_back('{1'b1, 32'hDEAD_BEEF, acc + 1});
    tick();
    bus0.req_valid = 1'b0; bus0.opcode = OP_STR; bus0.address = '1; bus0.data = 32'h0BAD_0BAD;
    total++; if ({bus0.bus_en, bus0.rw, bus0.busy, bus0.req_ready} !== 4'b1010) begin
      bad++; $display("FAIL ld_bus_ctl: got %b required 1010", {bus0.bus_en, bus0.rw, bus0.busy, bus0.req_ready}); end
    total++; if (bus0.addr_bus !== 16'h0040 || bus0.mem_dout !== 32'h0) begin
      bad++; $display("FAIL ld_bus_data: addr=%h dout=%h required 0040/0", bus0.addr_bus, bus0.mem_dout); end
    wait_resp0(5, got, is_ld, d, at);
    e = exp_q.pop_front();
    total++; if (!got || is_ld !== e.is_load || at != e.due) begin
      bad++; $display("FAIL ld_resp: got=%0b load=%0b cyc=%0d required load=%0b cyc=%0d", got, is_ld, at, e.is_load, e.due); end
    total++; if (d !== e.data || bus0.ldr_sel !== 1'b1 || bus0.bus_en !== 1'b0) begin
      bad++; $display("FAIL ld_data: data=%h sel=%b bus_en=%b required %h/1/0", d, bus0.ldr_sel, bus0.bus_en, e.data); end
    tick();
    total++; if (bus0.ldr_valid !== 1'b0 || bus0.req_ready !== 1'b1 || bus0.ldr_data !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL ld_after: valid=%b ready=%b data=%h required 0/1/deadbeef", bus0.ldr_valid, bus0.req_ready, bus0.ldr_data); end
    clear_inputs();
  endtask

  task automatic test_store_w3();
    int acc; exp_t e;
    bus3.mem_ready = 1'b1;
    bus3.req_valid = 1'b1; bus3.opcode = OP_STR; bus3.address = 32'h0000_0100; bus3.data = 32'h1234_5678;
    acc = cyc + 1;
    exp_q.push_back('{1'b0, 32'h0, acc + 4});
    tick();
    bus3.req_valid = 1'b0; bus3.data = 32'h0000_CAFE; bus3.address = 32'h0000_0999;
    for (int k = 0; k < 4; k++) begin
      total++; if ({bus3.bus_en, bus3.rw} !== 2'b11 || bus3.addr_bus !== 16'h0100 ||
                   bus3.mem_dout !== 32'h1234_5678 || bus3.store_done !== 1'b0) begin
        bad++; $display("FAIL st_bus k=%0d: en=%b rw=%b addr=%h dout=%h done=%b required 1/1/0100/12345678/0",
                        k, bus3.bus_en, bus3.rw, bus3.addr_bus, bus3.mem_dout, bus3.store_done); end
      bus3.mem_ready = (k != 1);
      tick();
    end
    e = exp_q.pop_front();
    total++; if (bus3.store_done !== 1'b1 || cyc != e.due || bus3.req_ready !== 1'b1 || bus3.bus_en !== 1'b0) begin
      bad++; $display("FAIL st_done: done=%b cyc=%0d ready=%b en=%b required 1/%0d/1/0",
                      bus3.store_done, cyc, bus3.req_ready, bus3.bus_en, e.due); end
    tick();
    total++; if (bus3.store_done !== 1'b0 || bus3.ldr_valid !== 1'b0) begin
      bad++; $display("FAIL st_pulse: done=%b ldr_valid=%b required 0/0", bus3.store_done, bus3.ldr_valid); end
    clear_inputs();
  endtask

  task automatic test_long_wait();
    int at; bit got, is_ld; logic [31:0] d; exp_t e;
    bus0.mem_ready = 1'b0; bus0.mem_din = 32'hA5A5_0F0F;
    bus0.req_valid = 1'b1; bus0.opcode = OP_LDR; bus0.address = 32'h0000_2222;
    tick();
    bus0.req_valid = 1'b0;
    for (int i = 0; i < LOW_CYC; i++) begin
      total++; if ({bus0.req_ready, bus0.busy, bus0.bus_en, bus0.ldr_valid} !== 4'b0110) begin
        bad++; $display("FAIL wait_hold i=%0d: ready/busy/en/valid=%b required 0110", i,
                        {bus0.req_ready, bus0.busy, bus0.bus_en, bus0.ldr_valid}); end
      tick();
    end
    bus0.mem_ready = 1'b1;
    exp_q.push_back('{1'b1, 32'hA5A5_0F0F, cyc + 1});
    wait_resp0(5, got, is_ld, d, at);
    e = exp_q.pop_front();
    total++; if (!got || is_ld !== 1'b1 || at != e.due || d !== e.data) begin
      bad++; $display("FAIL wait_resp: got=%0b load=%0b cyc=%0d data=%h required 1/1/%0d/%h", got, is_ld, at, d, e.due, e.data); end
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    int acc, at; bit got, is_ld, seen; logic [31:0] d; exp_t e;
    bus0.mem_ready = 1'b0;
    bus0.req_valid = 1'b1; bus0.opcode = OP_STR; bus0.address = 32'h0000_0300; bus0.data = 32'h0000_0055;
    tick();
    bus0.req_valid = 1'b0;
    tick();
    total++; if (bus0.bus_en !== 1'b1 || bus0.rw !== 1'b1) begin
      bad++; $display("FAIL rstmid_pre: en=%b rw=%b required 1/1", bus0.bus_en, bus0.rw); end
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    total++; if ({bus0.bus_en, bus0.req_ready, bus0.busy, bus0.store_done, bus0.rw} !== 5'b01000) begin
      bad++; $display("FAIL rstmid_post: en/ready/busy/done/rw=%b required 01000",
                      {bus0.bus_en, bus0.req_ready, bus0.busy, bus0.store_done, bus0.rw}); end
    bus0.mem_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus0.store_done !== 1'b0 || bus0.bus_en !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_quiet: activity=%b required 0", seen); end
    bus0.mem_din = 32'h0BAD_F00D;
    bus0.req_valid = 1'b1; bus0.opcode = OP_LDR; bus0.address = 32'h0000_0044;
    acc = cyc + 1;
    exp_q.push_back('{1'b1, 32'h0BAD_F00D, acc + 1});
    tick();
    bus0.req_valid = 1'b0;
    total++; if (bus0.addr_bus !== 16'h0044 || bus0.rw !== 1'b0) begin
      bad++; $display("FAIL rstmid_ld_bus: addr=%h rw=%b required 0044/0", bus0.addr_bus, bus0.rw); end
    wait_resp0(5, got, is_ld, d, at);
    e = exp_q.pop_front();
    total++; if (!got || is_ld !== 1'b1 || at != e.due || d !== e.data) begin
      bad++; $display("FAIL rstmid_ld: got=%0b load=%0b cyc=%0d data=%h required 1/1/%0d/%h", got, is_ld, at, d, e.due, e.data); end
    clear_inputs();
    tick();
  endtask

  task automatic test_back_to_back();
    int acc, at; bit got, is_ld, seen; logic [31:0] d; exp_t e;
    bus0.mem_ready = 1'b1;
    bus0.req_valid = 1'b1; bus0.opcode = 4'b0010; bus0.address = 32'h0000_0777;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus0.busy !== 1'b0 || bus0.bus_en !== 1'b0 || bus0.req_ready !== 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL nop_op: activity=%b required 0", seen); end
    bus0.mem_din = 32'h1111_2222;
    bus0.opcode = OP_LDR; bus0.address = 32'h0000_0010;
    acc = cyc + 1;
    exp_q.push_back('{1'b1, 32'h1111_2222, acc + 1});
    exp_q.push_back('{1'b0, 32'h0, acc + 4});
    tick();
    bus0.opcode = OP_STR; bus0.address = 32'h0000_0020; bus0.data = 32'h3333_4444;
    wait_resp0(5, got, is_ld, d, at);
    e = exp_q.pop_front();
    total++; if (!got || is_ld !== 1'b1 || at != e.due || d !== e.data) begin
      bad++; $display("FAIL b2b_ld: got=%0b load=%0b cyc=%0d data=%h required 1/1/%0d/%h", got, is_ld, at, d, e.due, e.data); end
    tick();
    total++; if (bus0.req_ready !== 1'b1 || bus0.bus_en !== 1'b0) begin
      bad++; $display("FAIL b2b_idle: ready=%b en=%b required 1/0", bus0.req_ready, bus0.bus_en); end
    tick();
    bus0.req_valid = 1'b0;
    total++; if ({bus0.bus_en, bus0.rw} !== 2'b11 || bus0.addr_bus !== 16'h0020 || bus0.mem_dout !== 32'h3333_4444) begin
      bad++; $display("FAIL b2b_st_bus: en=%b rw=%b addr=%h dout=%h required 1/1/0020/33334444",
                      bus0.bus_en, bus0.rw, bus0.addr_bus, bus0.mem_dout); end
    wait_resp0(5, got, is_ld, d, at);
    e = exp_q.pop_front();
    total++; if (!got || is_ld !== 1'b0 || at != e.due) begin
      bad++; $display("FAIL b2b_st: got=%0b load=%0b cyc=%0d required 1/0/%0d", got, is_ld, at, e.due); end
    total++; if (bus0.ldr_data !== 32'h1111_2222) begin
      bad++; $display("FAIL b2b_hold: ldr_data=%h required 11112222", bus0.ldr_data); end
    clear_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int acc, at; bit got, seen_ld, seen_err; logic [31:0] d; bit is_ld; exp_t e;
    bus0.mem_ready = 1'b0; bus0.mem_din = 32'h7777_8888;
    bus0.req_valid = 1'b1; bus0.opcode = OP_LDR; bus0.address = 32'h0000_0ABC;
    acc = cyc + 1;
    tick();
    bus0.req_valid = 1'b0;
`ifdef MEM_TIMEOUT_EN
    got = 1'b0; seen_ld = 1'b0; at = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus0.ldr_valid === 1'b1) seen_ld = 1'b1;
      if (bus0.err === 1'b1) begin got = 1'b1; at = cyc; break; end
      tick();
    end
    total++; if (!got || at != acc + 8) begin
      bad++; $display("FAIL to_err: got=%0b cyc=%0d required 1/%0d", got, at, acc + 8); end
    tick();
    if (bus0.ldr_valid === 1'b1) seen_ld = 1'b1;
    total++; if (seen_ld !== 1'b0 || bus0.err !== 1'b0 || bus0.busy !== 1'b0 || bus0.req_ready !== 1'b1) begin
      bad++; $display("FAIL to_after: ldr_seen=%b err=%b busy=%b ready=%b required 0/0/0/1",
                      seen_ld, bus0.err, bus0.busy, bus0.req_ready); end
    seen_err = 1'b0; d = '0; is_ld = 1'b0; e.due = 0;
`else
    seen_err = 1'b0; seen_ld = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus0.err !== 1'b0) seen_err = 1'b1;
      if (bus0.ldr_valid !== 1'b0) seen_ld = 1'b1;
      tick();
    end
    total++; if (seen_err !== 1'b0 || seen_ld !== 1'b0 || bus0.busy !== 1'b1) begin
      bad++; $display("FAIL no_to: err_seen=%b ldr_seen=%b busy=%b required 0/0/1", seen_err, seen_ld, bus0.busy); end
    bus0.mem_ready = 1'b1;
    exp_q.push_back('{1'b1, 32'h7777_8888, cyc + 1});
    wait_resp0(5, got, is_ld, d, at);
    e = exp_q.pop_front();
    total++; if (!got || is_ld !== 1'b1 || at != e.due || d !== e.data) begin
      bad++; $display("FAIL no_to_resp: got=%0b load=%0b cyc=%0d data=%h required 1/1/%0d/%h", got, is_ld, at, d, e.due, e.data); end
`endif
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_w0();
    test_store_w3();
    test_long_wait();
    test_reset_mid();
    test_back_to_back();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1);
  end

endmodule
